instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of addresses and instruction words.
REQ-002 Parameter MEMORY_DEPTH, default 51: number of instruction words in program memory; used only by the bounds check.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 Address  output  DATA_WIDTH: byte address to program memory; equals the current PC, combinational from the PC register.
REQ-007 Instruction  input  DATA_WIDTH: word returned by program memory for Address, valid in the same cycle.
REQ-008 Redirect_en  input  1: branch/jump redirect request.
REQ-009 Redirect_pc  input  DATA_WIDTH: redirect target byte address.
REQ-010 Out_valid  output  1: Out_* holds an instruction for decode.
REQ-011 Out_ready  input  1: decode accepts the held instruction this cycle.
REQ-012 Out_instruction  output  DATA_WIDTH: fetched instruction word.
REQ-013 Out_pc  output  DATA_WIDTH: byte address of Out_instruction.
REQ-014 Out_pc_plus4  output  DATA_WIDTH: Out_pc + 4, modulo 2^DATA_WIDTH.
REQ-015 Fault  output  1: sticky out-of-range fetch indication.

Function
REQ-016 States SHALL be FETCH, HOLD and FAULT; FAULT exists only when the bounds-check macro is defined.
REQ-017 Transfer to decode SHALL occur on an edge where Out_valid=1 and Out_ready=1.
REQ-018 FETCH: if the output register is empty or being transferred, capture Instruction, PC and PC+4 into Out_*, set Out_valid=1, advance PC by 4; the state remains FETCH.
REQ-019 If Out_valid=1 and Out_ready=0, the block SHALL go to HOLD; Out_* and the PC stay frozen until a transfer occurs.
REQ-020 HOLD->FETCH SHALL occur on transfer, with the next word captured on that same edge; there are no bubbles and sustained throughput is one instruction per cycle.
REQ-021 Redirect_en=1 SHALL take priority over every other event in FETCH and HOLD: PC <= {Redirect_pc[31:2],2'b00}, Out_valid <= 0, state <= FETCH.
REQ-022 Redirect_en=1 on a transfer edge: decode has consumed the held word; the redirect flush still applies and no new word is captured that edge.
REQ-023 Redirect latency: the target word SHALL appear on Out_* exactly 1 cycle after the redirect edge.
REQ-024 PC increment SHALL wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
REQ-025 Address[1:0] SHALL always be 2'b00.

Reset
REQ-026 While reset=1: PC=RESET_PC, Out_valid=0, Out_instruction=0, Out_pc=0, Out_pc_plus4=0, Fault=0, state=FETCH.
REQ-027 First capture SHALL occur on the first rising edge after reset deasserts; a reset mid-HOLD discards the held word.

Configuration
REQ-028 Macro FETCH_BOUNDS_CHECK_EN.
REQ-029 Defined: a capture with (PC>>2) >= MEMORY_DEPTH SHALL NOT occur; instead Fault <= 1, Out_valid <= 0, state <= FAULT; FAULT ignores Redirect_en and Out_ready and is left only by reset.
REQ-030 Undefined: Fault SHALL be tied 0, the FAULT state is absent, and the PC advances unconditionally.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum (FETCH, HOLD, FAULT), WORD_BYTES=4, and the default RESET_PC.
REQ-032 One sub-module pc_register SHALL hold the PC: async-reset register with load (redirect), increment and hold controls.

Verification
REQ-033 Reset, Out_ready=1, memory words 0x20080005, 0x20090007 -> Out_pc 0x0, then 0x4 on consecutive cycles; Out_valid=1 every cycle.
REQ-034 Out_ready=0 for 3 cycles at Out_pc=0x8 -> Out_* frozen at 0x8, Address=0xC held; release -> 0xC next cycle.
REQ-035 Redirect_en=1, Redirect_pc=0x2B during HOLD -> next cycle Out_valid=0; following cycle Out_pc=0x28.
REQ-036 Redirect and transfer on the same edge -> exactly one consumption of the old word, no duplicate, target word 1 cycle later.
REQ-037 With FETCH_BOUNDS_CHECK_EN, redirect to 0xCC (word 51) -> Fault=1, Out_valid=0 permanently; reset clears it. Without the macro, Out_pc=0xCC is emitted.
REQ-038 Redirect to 0xFFFF_FFFC with the macro undefined -> Out_pc_plus4=0x0, next Out_pc=0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_register.sv
// Program counter: word-aligned register with redirect load, increment and hold.
module pc_register
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_pc,
    input  logic                  i_incr,
    output logic [DATA_WIDTH-1:0] o_pc
);

    localparam logic [DATA_WIDTH-1:0] LP_INCR       = DATA_WIDTH'(WORD_BYTES);
    localparam logic [DATA_WIDTH-1:0] LP_ALIGN_MASK = ~DATA_WIDTH'(WORD_BYTES - 1);

    logic [DATA_WIDTH-1:0] r_pc;

    // Load wins over increment; the low address bits are always forced to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC & LP_ALIGN_MASK;
        end else if (i_load) begin
            r_pc <= i_load_pc & LP_ALIGN_MASK;
        end else if (i_incr) begin
            r_pc <= r_pc + LP_INCR;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with a one-entry output register and valid/ready handshake.
// Define FETCH_BOUNDS_CHECK_EN to trap fetches beyond MEMORY_DEPTH words into a sticky FAULT state.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 51,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Instruction,
    input  logic                  Redirect_en,
    input  logic [DATA_WIDTH-1:0] Redirect_pc,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output logic [DATA_WIDTH-1:0] Out_instruction,
    output logic [DATA_WIDTH-1:0] Out_pc,
    output logic [DATA_WIDTH-1:0] Out_pc_plus4,
    output logic                  Fault
);

    localparam logic [DATA_WIDTH-1:0] LP_INCR = DATA_WIDTH'(WORD_BYTES);

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [DATA_WIDTH-1:0] w_pc;
    logic                  w_load;
    logic                  w_capture;
    logic                  w_trip;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_instruction;
    logic [DATA_WIDTH-1:0] r_out_pc;
    logic [DATA_WIDTH-1:0] r_out_pc_plus4;

`ifdef FETCH_BOUNDS_CHECK_EN
    logic w_out_of_range;
    logic r_fault;

    assign w_out_of_range = (w_pc >> 2) >= DATA_WIDTH'(MEMORY_DEPTH);
`endif

    pc_register #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_register (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_load_pc (Redirect_pc),
        .i_incr    (w_capture),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The output slot accepts a new word when empty or when its word is leaving this edge.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_trip       = 1'b0;
        case (r_state)
            FETCH, HOLD: begin
                if (Redirect_en) begin
                    w_load       = 1'b1;
                    w_state_next = FETCH;
                end else if (!r_out_valid || Out_ready) begin
`ifdef FETCH_BOUNDS_CHECK_EN
                    if (w_out_of_range) begin
                        w_trip       = 1'b1;
                        w_state_next = FAULT;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = FETCH;
                    end
`else
                    w_capture    = 1'b1;
                    w_state_next = FETCH;
`endif
                end else begin
                    w_state_next = HOLD;
                end
            end
`ifdef FETCH_BOUNDS_CHECK_EN
            FAULT: w_state_next = FAULT;
`endif
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid       <= 1'b0;
            r_out_instruction <= '0;
            r_out_pc          <= '0;
            r_out_pc_plus4    <= '0;
        end else if (w_load || w_trip) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid       <= 1'b1;
            r_out_instruction <= Instruction;
            r_out_pc          <= w_pc;
            r_out_pc_plus4    <= w_pc + LP_INCR;
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_trip) begin
            r_fault <= 1'b1;
        end
    end

    assign Fault = r_fault;
`else
    assign Fault = 1'b0;
`endif

    assign Address         = w_pc;
    assign Out_valid       = r_out_valid;
    assign Out_instruction = r_out_instruction;
    assign Out_pc          = r_out_pc;
    assign Out_pc_plus4    = r_out_pc_plus4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised and directed bench for instruction_fetch against a behavioural fetch model.
module tb_instruction_fetch;

    localparam int DW    = 32;
    localparam int DEPTH = 51;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] Address;
    logic [DW-1:0] Instruction;
    logic          Redirect_en;
    logic [DW-1:0] Redirect_pc;
    logic          Out_valid;
    logic          Out_ready;
    logic [DW-1:0] Out_instruction;
    logic [DW-1:0] Out_pc;
    logic [DW-1:0] Out_pc_plus4;
    logic          Fault;

    logic [31:0] mem [64];
    int n_checks = 0;
    int n_errors = 0;

    // Model of the fetch stage: next PC, contents of the output slot, sticky fault.
    logic [31:0] m_pc, m_instr, m_opc, m_plus4;
    logic        m_valid, m_fault;

    assign Instruction = mem[Address[7:2]];

    always #5 clk = ~clk;

    instruction_fetch #(
        .DATA_WIDTH   (DW),
        .MEMORY_DEPTH (DEPTH),
        .RESET_PC     (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .Address         (Address),
        .Instruction     (Instruction),
        .Redirect_en     (Redirect_en),
        .Redirect_pc     (Redirect_pc),
        .Out_valid       (Out_valid),
        .Out_ready       (Out_ready),
        .Out_instruction (Out_instruction),
        .Out_pc          (Out_pc),
        .Out_pc_plus4    (Out_pc_plus4),
        .Fault           (Fault)
    );

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0;
        m_opc = 32'h0; m_plus4 = 32'h0; m_fault = 1'b0;
    endtask

    // Drive one cycle from a falling edge, advance the model at the rising edge, return on the next falling edge.
    task automatic cycle(input logic redir, input logic [31:0] rpc, input logic rdy);
        Redirect_en = redir; Redirect_pc = rpc; Out_ready = rdy;
        @(posedge clk);
        if (!m_fault) begin
            if (redir) begin
                m_pc = rpc & ~32'd3;
                m_valid = 1'b0;
            end else if (!m_valid || rdy) begin
`ifdef FETCH_BOUNDS_CHECK_EN
                if (m_pc / 4 >= DEPTH) begin
                    m_fault = 1'b1;
                    m_valid = 1'b0;
                end else
`endif
                begin
                    m_opc = m_pc;
                    m_instr = mem[m_pc[7:2]];
                    m_plus4 = m_pc + 32'd4;
                    m_valid = 1'b1;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        Redirect_en = 1'b0; Redirect_pc = 32'h0; Out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        Redirect_en = 1'b0; Redirect_pc = 32'h0; Out_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (Out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", Out_valid); end
        n_checks++; if (Out_instruction !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h want 0", Out_instruction); end
        n_checks++; if (Out_pc !== 32'h0 || Out_pc_plus4 !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got pc=%h pc4=%h want 0/0", Out_pc, Out_pc_plus4); end
        n_checks++; if (Fault !== 1'b0 || Address !== 32'h0) begin n_errors++; $display("FAIL reset_addr_fault: got addr=%h fault=%b want 0/0", Address, Fault); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(1'b0, 32'h0, 1'b1);
        n_checks++; if (Out_valid !== 1'b1 || Out_pc !== 32'h0) begin n_errors++; $display("FAIL reset_first_capture: got v=%b pc=%h want 1/0", Out_valid, Out_pc); end
        // Stall into HOLD, then reset asynchronously mid-cycle: the held word must vanish.
        cycle(1'b0, 32'h0, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (Out_valid !== 1'b0 || Address !== 32'h0) begin n_errors++; $display("FAIL reset_mid_hold: got v=%b addr=%h want 0/0", Out_valid, Address); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        n_checks++; if (Out_valid !== 1'b1 || Out_pc !== 32'h0 || Out_instruction !== 32'h2008_0005) begin n_errors++; $display("FAIL stream_w0: got v=%b pc=%h ins=%h want 1/0/20080005", Out_valid, Out_pc, Out_instruction); end
        n_checks++; if (Out_pc_plus4 !== 32'h4) begin n_errors++; $display("FAIL stream_pc4: got %h want 4", Out_pc_plus4); end
        cycle(1'b0, 32'h0, 1'b1);
        n_checks++; if (Out_valid !== 1'b1 || Out_pc !== 32'h4 || Out_instruction !== 32'h2009_0007) begin n_errors++; $display("FAIL stream_w1: got v=%b pc=%h ins=%h want 1/4/20090007", Out_valid, Out_pc, Out_instruction); end
        cycle(1'b0, 32'h0, 1'b1);
        n_checks++; if (Out_valid !== 1'b1 || Out_pc !== 32'h8) begin n_errors++; $display("FAIL stream_w2: got v=%b pc=%h want 1/8", Out_valid, Out_pc); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            n_checks++; if (Out_valid !== 1'b1 || Out_pc !== 32'h8 || Address !== 32'hC || Out_instruction !== mem[2]) begin n_errors++; $display("FAIL stall_%0d: got v=%b pc=%h addr=%h ins=%h want 1/8/c/%h", i, Out_valid, Out_pc, Address, Out_instruction, mem[2]); end
        end
        cycle(1'b0, 32'h0, 1'b1);
        n_checks++; if (Out_valid !== 1'b1 || Out_pc !== 32'hC || Out_instruction !== mem[3]) begin n_errors++; $display("FAIL stall_release: got v=%b pc=%h ins=%h want 1/c/%h", Out_valid, Out_pc, Out_instruction, mem[3]); end
    endtask

    task automatic test_redirect_hold();
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h2B, 1'b0);
        n_checks++; if (Out_valid !== 1'b0 || Address !== 32'h28) begin n_errors++; $display("FAIL redir_hold_flush: got v=%b addr=%h want 0/28", Out_valid, Address); end
        cycle(1'b0, 32'h0, 1'b0);
        n_checks++; if (Out_valid !== 1'b1 || Out_pc !== 32'h28 || Out_instruction !== mem[10]) begin n_errors++; $display("FAIL redir_hold_target: got v=%b pc=%h ins=%h want 1/28/%h", Out_valid, Out_pc, Out_instruction, mem[10]); end
    endtask

    task automatic test_redirect_transfer();
        int consumed;
        consumed = 0;
        if (Out_valid && Out_pc == 32'h28) consumed++;
        cycle(1'b1, 32'h40, 1'b1);
        n_checks++; if (Out_valid !== 1'b0) begin n_errors++; $display("FAIL redir_xfer_flush: got v=%b want 0", Out_valid); end
        if (Out_valid && Out_pc == 32'h28) consumed++;
        cycle(1'b0, 32'h0, 1'b1);
        n_checks++; if (Out_valid !== 1'b1 || Out_pc !== 32'h40 || Out_instruction !== mem[16]) begin n_errors++; $display("FAIL redir_xfer_target: got v=%b pc=%h ins=%h want 1/40/%h", Out_valid, Out_pc, Out_instruction, mem[16]); end
        if (Out_valid && Out_pc == 32'h28) consumed++;
        cycle(1'b0, 32'h0, 1'b1);
        n_checks++; if (consumed !== 1) begin n_errors++; $display("FAIL redir_xfer_once: got %0d consumptions want 1", consumed); end
    endtask

    task automatic test_bounds();
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'hCC, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
`ifdef FETCH_BOUNDS_CHECK_EN
        n_checks++; if (Fault !== 1'b1 || Out_valid !== 1'b0) begin n_errors++; $display("FAIL bounds_trip: got f=%b v=%b want 1/0", Fault, Out_valid); end
        cycle(1'b1, 32'h10, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        n_checks++; if (Fault !== 1'b1 || Out_valid !== 1'b0) begin n_errors++; $display("FAIL bounds_sticky: got f=%b v=%b want 1/0", Fault, Out_valid); end
        do_reset();
        n_checks++; if (Fault !== 1'b0) begin n_errors++; $display("FAIL bounds_clear: got f=%b want 0", Fault); end
`else
        n_checks++; if (Out_valid !== 1'b1 || Out_pc !== 32'hCC || Fault !== 1'b0) begin n_errors++; $display("FAIL bounds_off: got v=%b pc=%h f=%b want 1/cc/0", Out_valid, Out_pc, Fault); end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
`ifdef FETCH_BOUNDS_CHECK_EN
        n_checks++; if (Fault !== 1'b1 || Out_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_fault: got f=%b v=%b want 1/0", Fault, Out_valid); end
`else
        n_checks++; if (Out_pc !== 32'hFFFF_FFFC || Out_pc_plus4 !== 32'h0 || Address !== 32'h0) begin n_errors++; $display("FAIL wrap_top: got pc=%h pc4=%h addr=%h want fffffffc/0/0", Out_pc, Out_pc_plus4, Address); end
        cycle(1'b0, 32'h0, 1'b1);
        n_checks++; if (Out_valid !== 1'b1 || Out_pc !== 32'h0 || Out_instruction !== 32'h2008_0005) begin n_errors++; $display("FAIL wrap_next: got v=%b pc=%h ins=%h want 1/0/20080005", Out_valid, Out_pc, Out_instruction); end
`endif
    endtask

    task automatic test_random();
        logic        redir, rdy;
        logic [31:0] rpc;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            redir = ($urandom_range(0, 9) == 0);
            rpc   = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            rdy   = ($urandom_range(0, 3) != 0);
            cycle(redir, rpc, rdy);
            n_checks++;
            if (Out_valid !== m_valid || Fault !== m_fault || Address !== m_pc ||
                (m_valid && (Out_pc !== m_opc || Out_instruction !== m_instr || Out_pc_plus4 !== m_plus4))) begin
                n_errors++;
                $display("FAIL random_%0d: got v=%b f=%b a=%h pc=%h ins=%h pc4=%h want v=%b f=%b a=%h pc=%h ins=%h pc4=%h",
                         i, Out_valid, Fault, Address, Out_pc, Out_instruction, Out_pc_plus4,
                         m_valid, m_fault, m_pc, m_opc, m_instr, m_plus4);
            end
        end
    endtask

    initial begin
        reset = 1'b1; Redirect_en = 1'b0; Redirect_pc = 32'h0; Out_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0007;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect_hold();
        test_redirect_transfer();
        test_bounds();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
